// File: rtl/complex_vector_packer_8x8.sv
// Gathers a serial stream of complex elements into NI-lane blocks for the adder tree.
// Double-buffered: one bank fills while the other is held until the tree signals finish.
module complex_vector_packer_8x8 #(
    parameter int NI = 8,
    parameter int W  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic [NI*W-1:0] pack_data,
    output logic            pack_start,
    output logic [3:0]      pack_lanes,
    output logic            pack_last,
    input  logic            tree_finish,
    output logic            busy
);

    localparam int LW = $clog2(NI);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_DISP  = 2'd3;

    logic [1:0]      r_state    [2];
    logic [NI*W-1:0] r_bank     [2];
    logic [3:0]      r_lanes    [2];
    logic            r_last     [2];
    logic            r_fill_ptr;
    logic            r_disp_ptr;
    logic [LW-1:0]   r_lane_idx;
    logic            r_busy;
    logic            r_pack_start;
    logic [NI*W-1:0] r_pack_data;
    logic [3:0]      r_pack_lanes;
    logic            r_pack_last;

    logic w_fill_ok;
    logic w_accept;
    logic w_close;
    logic w_dispatch;
    logic w_release;

    assign w_fill_ok  = (r_state[r_fill_ptr] == S_EMPTY) || (r_state[r_fill_ptr] == S_FILL);
    assign in_ready   = w_fill_ok && !reset;
    assign w_accept   = in_valid && in_ready;
    assign w_close    = w_accept && (in_last || (r_lane_idx == LW'(NI - 1)));
    assign w_dispatch = !r_busy && (r_state[r_disp_ptr] == S_FULL);
    assign w_release  = r_busy && tree_finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= S_EMPTY;
                r_bank[b]  <= '0;
                r_lanes[b] <= '0;
                r_last[b]  <= 1'b0;
            end
            r_fill_ptr   <= 1'b0;
            r_disp_ptr   <= 1'b0;
            r_lane_idx   <= '0;
            r_busy       <= 1'b0;
            r_pack_start <= 1'b0;
            r_pack_data  <= '0;
            r_pack_lanes <= '0;
            r_pack_last  <= 1'b0;
        end else begin
            r_pack_start <= 1'b0;

            if (w_accept) begin
                // Lane 0 rewrites the whole bank so stale lanes from a previous block read as zero.
                if (r_lane_idx == '0) begin
                    r_bank[r_fill_ptr] <= {{((NI - 1) * W){1'b0}}, in_data};
                end else begin
                    for (int k = 0; k < NI; k++) begin
                        if (LW'(k) == r_lane_idx) begin
                            r_bank[r_fill_ptr][k*W +: W] <= in_data;
                        end
                    end
                end
                if (w_close) begin
                    r_state[r_fill_ptr] <= S_FULL;
                    r_lanes[r_fill_ptr] <= 4'(r_lane_idx) + 4'd1;
                    r_last[r_fill_ptr]  <= in_last;
                    r_fill_ptr          <= ~r_fill_ptr;
                    r_lane_idx          <= '0;
                end else begin
                    r_state[r_fill_ptr] <= S_FILL;
                    r_lane_idx          <= r_lane_idx + LW'(1);
                end
            end

            if (w_dispatch) begin
                r_state[r_disp_ptr] <= S_DISP;
                r_pack_data         <= r_bank[r_disp_ptr];
                r_pack_lanes        <= r_lanes[r_disp_ptr];
                r_pack_last         <= r_last[r_disp_ptr];
                r_pack_start        <= 1'b1;
                r_busy              <= 1'b1;
                r_disp_ptr          <= ~r_disp_ptr;
            end

            // Only one block is ever outstanding, so the held bank is the one behind the dispatch pointer.
            if (w_release) begin
                r_state[~r_disp_ptr] <= S_EMPTY;
                r_busy               <= 1'b0;
            end
        end
    end

    assign pack_data  = r_pack_data;
    assign pack_start = r_pack_start;
    assign pack_lanes = r_pack_lanes;
    assign pack_last  = r_pack_last;
    assign busy       = r_busy;

endmodule

// File: tb/tb_complex_vector_packer_8x8.sv
// Directed bench for complex_vector_packer_8x8: block packing, double buffering, release and reset.
module tb_complex_vector_packer_8x8;

    localparam int NI = 8;
    localparam int W  = 64;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic            in_ready;
    logic [NI*W-1:0] pack_data;
    logic            pack_start;
    logic [3:0]      pack_lanes;
    logic            pack_last;
    logic            tree_finish;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    complex_vector_packer_8x8 #(.NI(NI), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .pack_data   (pack_data),
        .pack_start  (pack_start),
        .pack_lanes  (pack_lanes),
        .pack_last   (pack_last),
        .tree_finish (tree_finish),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one element and hold it until accepted, with a bounded wait.
    task automatic send(input logic [W-1:0] d, input logic l);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_block();
        tree_finish = 1'b1;
        tick();
        tree_finish = 1'b0;
    endtask

    task automatic check_lane(input string tag, input int k, input logic [63:0] exp);
        logic [63:0] v;
        v = pack_data[k*W +: W];
        check($sformatf("%s_lane%0d", tag, k), v, exp);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        tree_finish = 1'b0;
        tick();
        tick();
        check("rst_pack_data", 64'(pack_data == '0), 64'd1);
        check("rst_pack_start", 64'(pack_start), 64'd0);
        check("rst_pack_lanes", 64'(pack_lanes), 64'd0);
        check("rst_pack_last", 64'(pack_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Full block of 8, values 1..8
        for (int k = 0; k < 8; k++) send(64'(k + 1), 1'b0);
        check("t1_no_early_start", 64'(pack_start), 64'd0);
        tick();
        check("t1_start", 64'(pack_start), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_lanes", 64'(pack_lanes), 64'd8);
        check("t1_last", 64'(pack_last), 64'd0);
        for (int k = 0; k < 8; k++) check_lane("t1", k, 64'(k + 1));
        tick();
        check("t1_start_pulse", 64'(pack_start), 64'd0);
        release_block();
        check("t1_release_busy", 64'(busy), 64'd0);

        // Short block closed by in_last
        send(64'hA, 1'b0);
        send(64'hB, 1'b0);
        send(64'hC, 1'b1);
        tick();
        check("t2_start", 64'(pack_start), 64'd1);
        check("t2_lanes", 64'(pack_lanes), 64'd3);
        check("t2_last", 64'(pack_last), 64'd1);
        check_lane("t2", 0, 64'hA);
        check_lane("t2", 1, 64'hB);
        check_lane("t2", 2, 64'hC);
        for (int k = 3; k < 8; k++) check_lane("t2", k, 64'h0);

        // Outputs hold across a long wait for finish
        for (int i = 0; i < 20; i++) tick();
        check("t6_hold_busy", 64'(busy), 64'd1);
        check("t6_hold_lanes", 64'(pack_lanes), 64'd3);
        check_lane("t6_hold", 2, 64'hC);
        release_block();
        check("t6_busy_cleared", 64'(busy), 64'd0);
        release_block();
        check("t6_idle_finish_busy", 64'(busy), 64'd0);
        check("t6_idle_finish_start", 64'(pack_start), 64'd0);
        check("t6_idle_finish_ready", 64'(in_ready), 64'd1);
        check_lane("t6_idle_finish", 2, 64'hC);
        check("t6_idle_finish_last", 64'(pack_last), 64'd1);

        // 24 back-to-back elements with the tree stalled
        for (int i = 0; i < 16; i++) send(64'(100 + i), 1'b0);
        check("t3_ready_low", 64'(in_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check_lane("t3_blk1", 0, 64'd100);
        check_lane("t3_blk1", 7, 64'd107);
        release_block();
        check("t3_rel_busy", 64'(busy), 64'd0);
        check("t3_rel_ready", 64'(in_ready), 64'd1);
        check("t3_rel_nostart", 64'(pack_start), 64'd0);
        tick();
        check("t3_blk2_start", 64'(pack_start), 64'd1);
        check("t3_blk2_ready", 64'(in_ready), 64'd1);
        check_lane("t3_blk2", 0, 64'd108);
        check_lane("t3_blk2", 7, 64'd115);
        for (int i = 16; i < 24; i++) send(64'(100 + i), 1'b0);
        check("t3_ready_low2", 64'(in_ready), 64'd0);
        tick();
        check("t3_blk3_wait", 64'(pack_start), 64'd0);
        check_lane("t3_blk2_held", 0, 64'd108);
        release_block();
        tick();
        check("t3_blk3_start", 64'(pack_start), 64'd1);
        check_lane("t3_blk3", 0, 64'd116);
        check_lane("t3_blk3", 7, 64'd123);
        release_block();

        // Completion of bank B on the same edge that releases bank A
        for (int i = 0; i < 8; i++) send(64'(200 + i), 1'b0);
        tick();
        check("t4_a_start", 64'(pack_start), 64'd1);
        for (int i = 0; i < 7; i++) send(64'(300 + i), 1'b0);
        check("t4_b_ready", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_data     = 64'd307;
        tree_finish = 1'b1;
        tick();
        in_valid    = 1'b0;
        tree_finish = 1'b0;
        check("t4_busy_cleared", 64'(busy), 64'd0);
        check("t4_no_start_yet", 64'(pack_start), 64'd0);
        tick();
        check("t4_b_start", 64'(pack_start), 64'd1);
        check("t4_b_lanes", 64'(pack_lanes), 64'd8);
        check_lane("t4_b", 0, 64'd300);
        check_lane("t4_b", 7, 64'd307);
        tick();
        check("t4_no_dup_start", 64'(pack_start), 64'd0);
        release_block();

        // Reset in mid-operation
        for (int i = 0; i < 8; i++) send(64'(400 + i), 1'b0);
        for (int i = 0; i < 5; i++) send(64'(500 + i), 1'b0);
        check("t5_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check("t5_rst_data", 64'(pack_data == '0), 64'd1);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_lanes", 64'(pack_lanes), 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        release_block();
        check("t5_stale_finish_busy", 64'(busy), 64'd0);
        check("t5_stale_finish_start", 64'(pack_start), 64'd0);
        for (int i = 0; i < 8; i++) send(64'(600 + i), 1'b0);
        tick();
        check("t5_fresh_start", 64'(pack_start), 64'd1);
        check("t5_fresh_lanes", 64'(pack_lanes), 64'd8);
        check("t5_fresh_last", 64'(pack_last), 64'd0);
        for (int k = 0; k < 8; k++) check_lane("t5_fresh", k, 64'(600 + k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
